// File: rtl/ysyx_22041412_clint_bridge_pkg.sv
// Shared definitions for the CLINT bridge: FSM states, timer rw_mode codes, access sizes, default addresses.
// Also holds the 32-bit word merge helper used for 4-byte mtimecmp stores.
package ysyx_22041412_clint_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_MERGE = 3'd2,
      ST_WR    = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   localparam logic [1:0] RW_NONE = 2'd0;
   localparam logic [1:0] RW_TIME = 2'd1;
   localparam logic [1:0] RW_CMP  = 2'd2;
   localparam logic [1:0] RW_WCMP = 2'd3;

   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [63:0] MTIMECMP_ADDR_DEF = 64'h0000_0000_0200_4000;
   localparam logic [63:0] MTIME_ADDR_DEF    = 64'h0000_0000_0200_BFF8;

   function automatic logic [63:0] merge_word(input logic [63:0] base,
                                              input logic [31:0] w,
                                              input logic        hi);
      return hi ? {w, base[31:0]} : {base[63:32], w};
   endfunction

endpackage

// File: rtl/ysyx_22041412_clint_bridge_if.sv
// LSU MMIO request/response channel; master = LSU, slave = CLINT bridge.
// Both directions use valid/ready; the slave holds a response until resp_ready.
interface ysyx_22041412_clint_bridge_if #(
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_wen;
   logic [1:0]        req_size;
   logic [63:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [63:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_size, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ysyx_22041412_clint_bridge.sv
// Core-side CLINT initiator: decodes LSU MMIO, drives timer rw_mode/wdata/upcmp, registers MTIP.
// Accept-to-response 1 (error) / 2 (load, 8B store) / 4 (4B store) cycles; one request in flight, response held until resp_ready.
module ysyx_22041412_clint_bridge
   import ysyx_22041412_clint_bridge_pkg::*;
#(
   parameter logic [63:0] MTIMECMP_ADDR = MTIMECMP_ADDR_DEF,
   parameter logic [63:0] MTIME_ADDR    = MTIME_ADDR_DEF,
   parameter int          ADDR_W        = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   ysyx_22041412_clint_bridge_if.slave        lsu,
   output logic                               tmr_enable_o,
   output logic [1:0]                         tmr_rw_mode_o,
   output logic [63:0]                        tmr_wdata_o,
   output logic                               tmr_upcmp_o,
   input  logic [63:0]                        tmr_rdata_i,
   input  logic                               tmr_irq_i,
   output logic                               mtip_o,
   input  logic                               step_cmp_i
);

   localparam logic [ADDR_W-1:0] CMP_A  = MTIMECMP_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] TIME_A = MTIME_ADDR[ADDR_W-1:0];

   state_e      state_q, state_d;
   logic        wen_q, wen_d;
   logic [1:0]  size_q, size_d;
   logic        hi_q, hi_d;
   logic        hit_time_q, hit_time_d;
   logic [31:0] wlo_q, wlo_d;
   logic [63:0] wval_q, wval_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        pend_q, pend_d;
   logic        upcmp_q, upcmp_d;
   logic        en_q;
   logic        mtip_q;

   logic              accept;
   logic [ADDR_W-1:0] base_addr;
   logic              hit_cmp, hit_time, req_err, want_step;

   assign accept    = lsu.req_valid && lsu.req_ready;
   assign base_addr = {lsu.req_addr[ADDR_W-1:3], 3'b000};
   assign hit_cmp   = (base_addr == CMP_A);
   assign hit_time  = (base_addr == TIME_A);

   always_comb begin
      req_err = 1'b0;
      if (!(hit_cmp || hit_time))                                  req_err = 1'b1;
      if (lsu.req_size != SIZE_W && lsu.req_size != SIZE_D)        req_err = 1'b1;
      if (lsu.req_size == SIZE_D && lsu.req_addr[2:0] != 3'b000)   req_err = 1'b1;
      if (lsu.req_size == SIZE_W && lsu.req_addr[1:0] != 2'b00)    req_err = 1'b1;
      if (lsu.req_wen && hit_time)                                 req_err = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      wen_d      = wen_q;
      size_d     = size_q;
      hi_d       = hi_q;
      hit_time_d = hit_time_q;
      wlo_d      = wlo_q;
      wval_d     = wval_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               wen_d      = lsu.req_wen;
               size_d     = lsu.req_size;
               hi_d       = lsu.req_addr[2];
               hit_time_d = hit_time;
               wlo_d      = lsu.req_wdata[31:0];
               wval_d     = lsu.req_wdata;
               rdata_d    = '0;
               err_d      = req_err;
               if (req_err)                       state_d = ST_RESP;
               else if (!lsu.req_wen)             state_d = ST_RD;
               else if (lsu.req_size == SIZE_D)   state_d = ST_WR;
               else                               state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (!wen_q) begin
               if (size_q == SIZE_W)
                  rdata_d = {32'b0, hi_q ? tmr_rdata_i[63:32] : tmr_rdata_i[31:0]};
               else
                  rdata_d = tmr_rdata_i;
               state_d = ST_RESP;
            end else begin
               wval_d  = tmr_rdata_i;
               state_d = ST_MERGE;
            end
         end
         ST_MERGE: begin
            wval_d  = merge_word(wval_q, wlo_q, hi_q);
            state_d = ST_WR;
         end
         ST_WR: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (lsu.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A step pulse never lands on the write cycle; it is parked and released right after it.
   always_comb begin
      want_step = pend_q || step_cmp_i;
      upcmp_d   = 1'b0;
      pend_d    = 1'b0;
      if (state_d == ST_WR) pend_d  = want_step;
      else                  upcmp_d = want_step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wen_q      <= 1'b0;
         size_q     <= 2'b00;
         hi_q       <= 1'b0;
         hit_time_q <= 1'b0;
         wlo_q      <= '0;
         wval_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
         upcmp_q    <= 1'b0;
         en_q       <= 1'b0;
         mtip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wen_q      <= wen_d;
         size_q     <= size_d;
         hi_q       <= hi_d;
         hit_time_q <= hit_time_d;
         wlo_q      <= wlo_d;
         wval_q     <= wval_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         upcmp_q    <= upcmp_d;
         en_q       <= 1'b1;
         mtip_q     <= tmr_irq_i;
      end
   end

   // Gated by rst so an in-flight write is dropped in the reset cycle itself.
   always_comb begin
      tmr_rw_mode_o = RW_NONE;
      if (!rst) begin
         if (state_q == ST_RD)      tmr_rw_mode_o = hit_time_q ? RW_TIME : RW_CMP;
         else if (state_q == ST_WR) tmr_rw_mode_o = RW_WCMP;
      end
   end

   assign tmr_wdata_o    = (state_q == ST_WR) ? wval_q : 64'h0;
   assign tmr_upcmp_o    = upcmp_q;
   assign tmr_enable_o   = en_q;
   assign mtip_o         = mtip_q;

   assign lsu.req_ready  = (state_q == ST_IDLE);
   assign lsu.resp_valid = (state_q == ST_RESP);
   assign lsu.resp_rdata = rdata_q;
   assign lsu.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22041412_clint_bridge.sv
// Bench for the CLINT bridge: a small timer model plus a transaction-level reference for loads/stores.
module tb_ysyx_22041412_clint_bridge;

   localparam logic [63:0] A_CMP  = 64'h0200_4000;
   localparam logic [63:0] A_TIME = 64'h0200_BFF8;

   logic        clk = 1'b0;
   logic        rst;
   logic        tmr_enable, tmr_upcmp, tmr_irq, mtip, step_cmp;
   logic [1:0]  rw;
   logic [63:0] twdata, trdata;
   logic [63:0] mtime_m, cmp_m, cmp_load_val;
   logic        cmp_load;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ysyx_22041412_clint_bridge_if #(.ADDR_W(64)) bus();

   ysyx_22041412_clint_bridge #(
      .MTIMECMP_ADDR(A_CMP), .MTIME_ADDR(A_TIME), .ADDR_W(64)
   ) dut (
      .clk(clk), .rst(rst), .lsu(bus.slave),
      .tmr_enable_o(tmr_enable), .tmr_rw_mode_o(rw), .tmr_wdata_o(twdata),
      .tmr_upcmp_o(tmr_upcmp), .tmr_rdata_i(trdata), .tmr_irq_i(tmr_irq),
      .mtip_o(mtip), .step_cmp_i(step_cmp)
   );

   // Timer model: combinational reads, mtimecmp written on rw_mode=3.
   always_comb begin
      trdata = 64'h0;
      if (rw == 2'd1)      trdata = mtime_m;
      else if (rw == 2'd2) trdata = cmp_m;
   end

   always @(posedge clk) begin
      if (rw == 2'd3)    cmp_m <= twdata;
      else if (cmp_load) cmp_m <= cmp_load_val;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmp(input logic [63:0] v);
      cmp_load_val = v;
      cmp_load = 1'b1;
      cyc();
      cmp_load = 1'b0;
   endtask

   function automatic bit ref_err(input logic [63:0] a, input bit wen, input logic [1:0] sz);
      logic [63:0] base;
      base = a - (a % 8);
      if (base != A_CMP && base != A_TIME) return 1'b1;
      if (sz != 2'd2 && sz != 2'd3)        return 1'b1;
      if (sz == 2'd3 && (a % 8) != 0)      return 1'b1;
      if (sz == 2'd2 && (a % 4) != 0)      return 1'b1;
      if (wen && base == A_TIME)           return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_txn(input logic [63:0] a, input bit wen, input logic [1:0] sz,
                         input logic [63:0] wd, input int hold);
      bit          e;
      logic [63:0] base, word, exp_rd, exp_cmp, cmp_before, mask, r0;
      int          sh, exp_lat, exp_reads, exp_writes, lat, reads, writes;
      logic        e0;

      e          = ref_err(a, wen, sz);
      base       = a - (a % 8);
      cmp_before = cmp_m;
      word       = (base == A_TIME) ? mtime_m : cmp_before;
      sh         = ((a / 4) % 2) * 32;
      mask       = 64'hFFFF_FFFF << sh;
      exp_rd     = 64'h0;
      exp_cmp    = cmp_before;
      if (!e && !wen) exp_rd  = (sz == 2'd3) ? word : ((word >> sh) & 64'hFFFF_FFFF);
      if (!e && wen)  exp_cmp = (sz == 2'd3) ? wd : ((cmp_before & ~mask) | ((wd & 64'hFFFF_FFFF) << sh));
      exp_lat    = e ? 1 : (!wen ? 2 : (sz == 2'd3 ? 2 : 4));
      exp_reads  = (e || (wen && sz == 2'd3)) ? 0 : 1;
      exp_writes = (!e && wen) ? 1 : 0;

      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wen = wen;
      bus.req_size = sz; bus.req_wdata = wd; bus.resp_ready = 1'b0;
      chk("req_ready_idle", bus.req_ready, 1);
      cyc();
      bus.req_valid = 1'b0;
      bus.req_addr  = {$urandom, $urandom};
      bus.req_wdata = {$urandom, $urandom};
      bus.req_wen   = 1'($urandom);
      bus.req_size  = 2'($urandom);

      lat = 0; reads = 0; writes = 0;
      for (int k = 1; k <= 12; k++) begin
         if (rw inside {2'd1, 2'd2}) begin
            reads++;
            chk("rd_mode", rw, (base == A_TIME) ? 2'd1 : 2'd2);
         end
         if (rw == 2'd3) writes++;
         if (bus.resp_valid) begin
            lat = k;
            break;
         end
         cyc();
      end
      chk("latency", lat, exp_lat);
      chk("rdata", bus.resp_rdata, exp_rd);
      chk("err", bus.resp_err, e);
      chk("timer_reads", reads, exp_reads);
      chk("timer_writes", writes, exp_writes);

      r0 = bus.resp_rdata;
      e0 = bus.resp_err;
      for (int h = 0; h < hold; h++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = A_CMP;
         bus.req_size  = 2'd3;
         bus.req_wen   = 1'b0;
         cyc();
         chk("hold_valid", bus.resp_valid, 1);
         chk("hold_rdata", bus.resp_rdata, r0);
         chk("hold_err", bus.resp_err, e0);
         chk("hold_req_ready", bus.req_ready, 0);
         chk("hold_rw", rw, 0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      cyc();
      bus.resp_ready = 1'b0;
      chk("post_valid", bus.resp_valid, 0);
      chk("post_req_ready", bus.req_ready, 1);
      chk("post_rw", rw, 0);
      chk("cmp_value", cmp_m, exp_cmp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] addrs [8];
      logic [63:0] v;
      int          wcnt;

      addrs = '{A_TIME, A_TIME + 4, A_CMP, A_CMP + 4,
                64'h0200_0000, A_CMP + 2, A_CMP + 1, A_TIME + 6};

      rst = 1'b1; step_cmp = 1'b0; tmr_irq = 1'b0; cmp_load = 1'b0; cmp_load_val = '0;
      mtime_m = 64'h0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
      bus.req_size = 2'd0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      cyc();
      cyc();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_rdata", bus.resp_rdata, 0);
      chk("rst_err", bus.resp_err, 0);
      chk("rst_rw", rw, 0);
      chk("rst_wdata", twdata, 0);
      chk("rst_upcmp", tmr_upcmp, 0);
      chk("rst_mtip", mtip, 0);
      chk("rst_enable", tmr_enable, 0);
      rst = 1'b0;
      set_cmp(64'h0000_0001_0000_0010);
      chk("enable_on", tmr_enable, 1);

      mtime_m = 64'h1234_5678_9ABC_DEF0;
      do_txn(A_TIME, 1'b0, 2'd3, 64'h0, 0);
      do_txn(A_CMP + 4, 1'b1, 2'd2, 64'h0000_0000_DEAD_BEEF, 0);
      chk("merge_result", cmp_m, 64'hDEAD_BEEF_0000_0010);
      do_txn(A_TIME, 1'b1, 2'd3, 64'h5555, 0);
      do_txn(A_CMP + 4, 1'b0, 2'd3, 64'h0, 0);
      do_txn(64'h0200_0000, 1'b0, 2'd3, 64'h0, 0);
      do_txn(A_CMP, 1'b0, 2'd3, 64'h0, 5);
      do_txn(A_TIME + 4, 1'b0, 2'd2, 64'h0, 1);

      // Step pulse while idle.
      step_cmp = 1'b1;
      #1;
      chk("upcmp_idle_pre", tmr_upcmp, 0);
      cyc();
      step_cmp = 1'b0;
      chk("upcmp_idle_pulse", tmr_upcmp, 1);
      cyc();
      chk("upcmp_idle_end", tmr_upcmp, 0);

      // Step on the accept cycle and again during WR: one pulse, right after WR.
      bus.req_valid = 1'b1; bus.req_addr = A_CMP; bus.req_wen = 1'b1;
      bus.req_size = 2'd3; bus.req_wdata = 64'hCAFE_0000_0000_0042;
      step_cmp = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      chk("wr_rw", rw, 3);
      chk("wr_wdata", twdata, 64'hCAFE_0000_0000_0042);
      chk("upcmp_in_wr", tmr_upcmp, 0);
      cyc();
      step_cmp = 1'b0;
      chk("upcmp_after_wr", tmr_upcmp, 1);
      cyc();
      chk("upcmp_single", tmr_upcmp, 0);
      bus.resp_ready = 1'b1;
      cyc();
      bus.resp_ready = 1'b0;
      chk("upcmp_idle_again", tmr_upcmp, 0);

      // MTIP follows the interrupt with one cycle of delay.
      tmr_irq = 1'b1;
      #1;
      chk("mtip_pre", mtip, 0);
      cyc();
      chk("mtip_rise", mtip, 1);
      tmr_irq = 1'b0;
      cyc();
      chk("mtip_fall", mtip, 0);

      // Reset during MERGE abandons the write.
      set_cmp(64'h0BAD_F00D_1111_2222);
      bus.req_valid = 1'b1; bus.req_addr = A_CMP; bus.req_wen = 1'b1;
      bus.req_size = 2'd2; bus.req_wdata = 64'h7777_7777;
      cyc();
      bus.req_valid = 1'b0;
      chk("rstmid_rd", rw, 2);
      cyc();
      chk("rstmid_merge_rw", rw, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rstmid_req_ready", bus.req_ready, 1);
      chk("rstmid_rw", rw, 0);
      chk("rstmid_resp_valid", bus.resp_valid, 0);
      wcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (rw == 2'd3) wcnt++;
         cyc();
      end
      chk("rstmid_no_write", wcnt, 0);
      chk("rstmid_cmp", cmp_m, 64'h0BAD_F00D_1111_2222);
      chk("rstmid_enable", tmr_enable, 1);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         logic [1:0] sz;
         mtime_m = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) set_cmp({$urandom, $urandom});
         v  = addrs[$urandom_range(0, 7)];
         sz = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         do_txn(v, 1'($urandom), sz, {$urandom, $urandom}, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22041412_clint_bridge.md
Name: ysyx_22041412_clint_bridge

Overview:
Core-side initiator for the machine timer unit. It accepts LSU MMIO requests on a valid/ready channel and decodes the CLINT addresses. It drives the timer's rw_mode/wr_data/upcmptime controls, captures the returned read data and answers the LSU on a response channel. It also registers the timer interrupt into a core-facing MTIP bit.

Parameters:
MTIMECMP_ADDR, 64'h0200_4000, byte address of mtimecmp (8-byte aligned)
MTIME_ADDR, 64'h0200_BFF8, byte address of mtime (8-byte aligned)
ADDR_W, 64, LSU address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset; clk is the only clock
req_valid  in  1  LSU request valid
req_ready  out  1  bridge can accept a request
req_addr  in  ADDR_W  byte address
req_wen  in  1  1=store, 0=load
req_size  in  2  2=4 bytes, 3=8 bytes; other values are illegal
req_wdata  in  64  store data, low-aligned
resp_valid  out  1  response valid
resp_ready  in  1  LSU accepts response
resp_rdata  out  64  load data, low-aligned, zero-extended
resp_err  out  1  access fault
tmr_enable  out  1  timer count enable
tmr_rw_mode  out  2  0 none, 1 read mtime, 2 read mtimecmp, 3 write mtimecmp
tmr_wdata  out  64  full 64-bit mtimecmp write value
tmr_upcmp  out  1  one-cycle step pulse to the timer
tmr_rdata  in  64  timer read data, combinational from tmr_rw_mode
tmr_irq  in  1  timer interrupt level
mtip  out  1  registered MTIP for the CSR unit
step_cmp  in  1  software/CSR request to advance mtimecmp by the timer's step

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, tmr_rw_mode=0, tmr_wdata=0, tmr_upcmp=0, mtip=0, tmr_enable=0. tmr_enable goes to 1 on the first cycle after rst deasserts and stays 1.
- Decode, on the accept cycle (req_valid && req_ready), using the address with bits [2:0] masked:
  - hit_cmp when it equals MTIMECMP_ADDR.
  - hit_time when it equals MTIME_ADDR.
  - hi = addr[2].
- Error conditions, all taking IDLE->RESP with resp_err=1, resp_rdata=0 and no timer access:
  - no hit;
  - size 3 with addr[2:0]!=0;
  - size 2 with addr[1:0]!=0;
  - size not in {2,3};
  - any store to mtime (mtime is read-only).
- FSM states: IDLE, RD, MERGE, WR, RESP.
  - IDLE: req_ready=1. On accept: load -> RD; store of size 3 -> WR; store of size 2 -> RD (read-modify-write).
  - RD: tmr_rw_mode = 1 (hit_time) or 2 (hit_cmp). tmr_rdata is sampled at the end of this cycle.
    - For a load: if size 2, select the hi/lo word and zero-extend it into resp_rdata; go to RESP.
    - For a size-2 store: hold the sampled value in the merge register; go to MERGE.
  - MERGE: replace word[hi] of the held value with req_wdata[31:0]; go to WR.
  - WR: tmr_rw_mode=3 with tmr_wdata=merged value (or req_wdata for size 3) for exactly one cycle; go to RESP with resp_rdata=0.
  - RESP: resp_valid=1 and outputs held stable until resp_ready; then -> IDLE. A new request is not accepted in the same cycle as the response handshake.
- tmr_rw_mode is 0 in every state other than RD and WR.
- Latency from accept to resp_valid:
  - load: 2 cycles;
  - 8-byte store: 2 cycles;
  - 4-byte store: 4 cycles;
  - error: 1 cycle.
- Request fields (addr, wen, size, wdata) are latched at accept. The LSU may change them afterwards.
- tmr_upcmp: a step_cmp pulse produces a one-cycle pulse in the next cycle.
  - If step_cmp arrives while the FSM is in WR, the pulse is deferred to the first cycle after WR.
  - Pending pulses do not accumulate beyond 1; a second step_cmp while one is pending is dropped.
- mtip = tmr_irq registered (1-cycle delay), no masking; masking lives in the CSR unit.
- Reset mid-transaction: state returns to IDLE and any in-flight write is abandoned. tmr_rw_mode=0 from the reset cycle on.

Decomposition:
- Shared package holds: FSM state encoding; rw_mode constants (RW_NONE=0, RW_TIME=1, RW_CMP=2, RW_WCMP=3); size codes; default CLINT addresses.
- No sub-module; the decode and merge logic is small enough to stay inline.

Test Plan:
- 8-byte load at 0x0200_BFF8 with tmr_rdata=64'h1234_5678_9ABC_DEF0 -> rw_mode=1 for one cycle; resp_valid 2 cycles after accept; rdata=64'h1234_5678_9ABC_DEF0; err=0.
- 4-byte store 0xDEAD_BEEF at 0x0200_4004 with current cmp=64'h0000_0001_0000_0010 -> RD(rw=2), MERGE, then WR with tmr_wdata=64'hDEAD_BEEF_0000_0010; resp 4 cycles after accept.
- 8-byte store to 0x0200_BFF8 -> resp_err=1 after 1 cycle; rw_mode stays 0 throughout.
- Misaligned 8-byte load at 0x0200_4004 and a load at unmapped 0x0200_0000 -> resp_err=1, rdata=0, no timer access.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid, rdata and err stable; req_ready=0; a req_valid presented meanwhile is not accepted.
- step_cmp asserted during WR -> tmr_upcmp pulses once, in the cycle after WR. tmr_irq rising -> mtip rises exactly 1 cycle later.
- rst asserted during MERGE -> the next cycle is IDLE with req_ready=1 and rw_mode=0; no rw_mode=3 is ever issued for that request.
